// File: rtl/agc_pkg.sv
// Shared types and helpers for the gain-shift AGC.
// Build option: AGC_DEADBAND_EN (see gain_shift_agc.sv).
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } agc_state_e;

    localparam int SHIFT_W = 5;

    // Shift that keeps one headroom bit in the output slice.
    function automatic logic [SHIFT_W-1:0] ideal_shift(
        input int p,
        input int out_w,
        input int shift_max
    );
        int s;
        s = p - out_w + 2;
        if (s < 0) s = 0;
        if (s > shift_max) s = shift_max;
        return SHIFT_W'(s);
    endfunction

endpackage

// File: rtl/msb_encoder.sv
// Priority encoder: index of the highest set bit plus a zero flag.
// Purely combinational.
module msb_encoder #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    output logic [IDX_W-1:0]  idx,
    output logic              zero
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) idx = IDX_W'(i);
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/gain_shift_agc.sv
// Per-frame automatic gain shift with fast attack and held one-step decay.
// Build option AGC_DEADBAND_EN widens the decay threshold by one step.
module gain_shift_agc
    import agc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int OUT_W       = 16,
    parameter int SHIFT_MAX   = 16,
    parameter int INIT_SHIFT  = 8,
    parameter int HOLD_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ms_in,
    input  logic [DATA_W-1:0] max_in,
    input  logic              agc_en,
    input  logic [4:0]        man_shift,
    output logic [15:0]       scaled_coeff,
    output logic              coeff_upd,
    output logic              locked,
    output logic              frame_drop
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_EVAL   = EVAL;
    localparam logic [1:0] ST_UPDATE = UPDATE;

    logic [1:0]         state;
    logic [DATA_W-1:0]  peak;
    logic [IDX_W-1:0]   msb_idx;
    logic               peak_zero;
    logic [SHIFT_W-1:0] s_ideal;
    logic [SHIFT_W-1:0] cur;
    logic [SHIFT_W-1:0] cur_nxt;
    logic [SHIFT_W-1:0] man_clamp;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_nxt;
    logic [CNT_W-1:0]   stable_cnt;
    logic [CNT_W-1:0]   stable_nxt;
    logic               dec_cond;

    msb_encoder #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) u_enc (
        .data(peak),
        .idx (msb_idx),
        .zero(peak_zero)
    );

    assign man_clamp = (man_shift > SHIFT_W'(SHIFT_MAX))
                     ? SHIFT_W'(SHIFT_MAX) : man_shift;

`ifdef AGC_DEADBAND_EN
    // One-step deadband stops toggling on peaks near a bit boundary.
    assign dec_cond = ({1'b0, s_ideal} + 6'd2) <= {1'b0, cur};
`else
    assign dec_cond = s_ideal < cur;
`endif

    always_comb begin
        cur_nxt    = cur;
        hold_nxt   = hold_cnt;
        stable_nxt = stable_cnt;
        if (!agc_en) begin
            cur_nxt    = man_clamp;
            hold_nxt   = '0;
            stable_nxt = '0;
        end else if (state == ST_UPDATE) begin
            if (s_ideal > cur) begin
                cur_nxt  = s_ideal;
                hold_nxt = '0;
            end else if (dec_cond) begin
                if (hold_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                    cur_nxt  = cur - SHIFT_W'(1);
                    hold_nxt = '0;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end else begin
                hold_nxt = '0;
            end
            if (cur_nxt != cur)
                stable_nxt = '0;
            else if (stable_cnt != CNT_W'(HOLD_FRAMES))
                stable_nxt = stable_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            peak       <= '0;
            s_ideal    <= '0;
            cur        <= SHIFT_W'(INIT_SHIFT);
            hold_cnt   <= '0;
            stable_cnt <= '0;
            coeff_upd  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            cur        <= cur_nxt;
            hold_cnt   <= hold_nxt;
            stable_cnt <= stable_nxt;
            coeff_upd  <= cur_nxt != cur;
            frame_drop <= ms_in && (state != ST_IDLE);
            unique case (state)
                ST_IDLE: begin
                    if (ms_in) begin
                        peak  <= max_in;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    s_ideal <= peak_zero
                             ? ideal_shift(-1, OUT_W, SHIFT_MAX)
                             : ideal_shift(int'(msb_idx), OUT_W, SHIFT_MAX);
                    state   <= ST_UPDATE;
                end
                ST_UPDATE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign scaled_coeff = {{(16 - SHIFT_W){1'b0}}, cur};
    assign locked       = stable_cnt == CNT_W'(HOLD_FRAMES);

endmodule

// File: doc/gain_shift_agc.md
# gain_shift_agc

Automatic gain controller for the 32-bit to 16-bit digital-gain stage. Once per frame it samples the frame peak from the max tracker and computes the bit-select shift that the adjust stage uses as `scaled_coeff`. The shift rises immediately when the peak gets larger (attack) and falls one step at a time after a hold period (decay). It sits between the max tracker's `max` output and the gain stage's `scaled_coeff` input, and includes a manual-override path for host control.

## Interface
Parameters:
- `DATA_W`, 32: width of the peak input.
- `OUT_W`, 16: width of the gain-stage output slice.
- `SHIFT_MAX`, 16: largest legal shift.
- `INIT_SHIFT`, 8: shift value after reset.
- `HOLD_FRAMES`, 4: number of consecutive "decrease" frames required before a one-step decay.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous active-high reset.
- `ms_in`, in, 1: one-cycle frame-boundary pulse. Same signal that feeds the max tracker.
- `max_in`, in, DATA_W: unsigned peak of the completed frame. Valid in the cycle `ms_in`=1.
- `agc_en`, in, 1: 1 selects automatic mode; 0 selects manual mode.
- `man_shift`, in, 5: shift used in manual mode. Values above SHIFT_MAX are clamped to SHIFT_MAX.
- `scaled_coeff`, out, 16: current shift, zero-extended. Reset value INIT_SHIFT.
- `coeff_upd`, out, 1: one-cycle pulse when `scaled_coeff` changes value. Reset value 0.
- `locked`, out, 1: no shift change for HOLD_FRAMES consecutive evaluated frames. Reset value 0.
- `frame_drop`, out, 1: one-cycle pulse when an `ms_in` arrives while the FSM is busy. Reset value 0.

## Operation
- FSM states: IDLE → EVAL → UPDATE → IDLE.
  - IDLE: waits for `ms_in`. On `ms_in`, registers `max_in` and moves to EVAL.
  - EVAL: the priority encoder produces p, the index of the highest set bit of the latched peak; p = -1 for a zero peak. Computes s_ideal = clamp(p - OUT_W + 2, 0, SHIFT_MAX). This keeps one headroom bit in the 16-bit slice.
  - UPDATE: applies the decision rule below, then returns to IDLE.
- Decision rule (automatic mode), with `cur` the current shift:
  - s_ideal > cur: cur <= s_ideal in a single step; hold counter cleared.
  - Decrease condition true: hold counter +1. When the counter reaches HOLD_FRAMES, cur <= cur - 1 and the counter clears.
  - Otherwise: hold counter cleared.
  - cur never goes below 0 or above SHIFT_MAX.
- `locked`: a stable-frame counter increments on each UPDATE with no change and saturates at HOLD_FRAMES. `locked` = (counter == HOLD_FRAMES). Any change clears the counter.
- Manual mode (`agc_en`=0):
  - cur follows the clamped `man_shift` with 1-cycle register latency, in any state.
  - Hold and stable counters held at 0; `locked`=0.
  - FSM still runs but UPDATE writes nothing.
- Mode switch 0→1: automatic evaluation starts from the current manual shift. No jump.
- `ms_in` in EVAL or UPDATE: the pulse is ignored and `frame_drop` pulses the next cycle.
- `rst` mid-operation: FSM returns to IDLE, cur = INIT_SHIFT, all counters 0, latched peak discarded.

## Timing
- `ms_in` at cycle T:
  - EVAL at T+1.
  - UPDATE at T+2.
  - `scaled_coeff` and `coeff_upd` valid at T+3, i.e. 3-cycle latency from the frame boundary.
- Manual mode: `scaled_coeff` reflects a `man_shift` change 1 cycle later; `coeff_upd` pulses with it.
- Minimum legal frame period: 3 cycles. Back-to-back `ms_in` closer than that produces `frame_drop`.
- `coeff_upd` fires only when the value actually differs from its previous value.

## Configuration
- Macro `AGC_DEADBAND_EN`:
  - Defined: the decrease condition is s_ideal <= cur - 2. This gives a one-step deadband and prevents toggling on peaks near a bit boundary.
  - Undefined: the decrease condition is s_ideal < cur.
- The attack rule is identical in both builds.

## Structure
- Shared package `agc_pkg`: FSM state enum (IDLE, EVAL, UPDATE), shift-width constant (5), and the s_ideal clamp function.
- Sub-module `msb_encoder`: DATA_W-input priority encoder. Outputs the index and a `zero` flag; purely combinational; registered in EVAL.

## Test plan
- Reset, then `ms_in` with `max_in`=0x0000_7FFF (p=14, s_ideal=0), `agc_en`=1 → no attack; decay reaches 7 after HOLD_FRAMES frames, with a `coeff_upd` pulse at T+3 of the 4th frame.
- From shift 0, `max_in`=0x4000_0000 (p=30, s_ideal=16) → `scaled_coeff`=16 at T+3 in one step; `coeff_upd` for exactly 1 cycle.
- Shift 10, alternating frames with s_ideal 9 and 10 → no decay, hold counter never reaches 4.
  - Same stimulus with s_ideal held at 9: decays to 9 without the macro and stays at 10 with the macro.
- `agc_en`=0, `man_shift`=20 → `scaled_coeff`=16 (clamped) one cycle later; `locked`=0; `ms_in` peaks cause no change.
- `ms_in` at T and again at T+1 → `frame_drop` pulse at T+2; the result follows the first frame only.
- `rst` asserted during EVAL → `scaled_coeff`=8, `coeff_upd`=0, `locked`=0 the next cycle; no update from the pending frame.
